// File: rtl/index_unpacked_pkg.sv
// rtl/index_unpacked_pkg.sv - shared types, FSM states and reset values for the index streamer
// Contents: entry_t / entry_arr_t (default 3 x 8-bit geometry), state_t, reset_byte().
// Optional macro INDEX_UNPACKED_STREAMER_CSUM_EN adds the CSUM state to state_t.
package index_unpacked_pkg;

    localparam int DEF_DEPTH = 3;
    localparam int DEF_WIDTH = 8;

    typedef logic [DEF_WIDTH-1:0] entry_t;
    typedef entry_t entry_arr_t [DEF_DEPTH];

`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2,
        CSUM   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;
`endif

    // Reset pattern AA, BB, CC, ... computed in 8-bit arithmetic (wraps at 256);
    // callers zero-extend or truncate to their entry width.
    function automatic logic [7:0] reset_byte(input int i);
        logic [7:0] k;
        k = 8'(i);
        return 8'hAA + k * 8'h11;
    endfunction

endpackage

// File: rtl/index_unpacked_streamer_if.sv
// rtl/index_unpacked_streamer_if.sv - output beat stream interface for the index streamer
// Signals: out_valid/out_data/out_idx (master -> slave), out_ready (slave -> master).
interface index_unpacked_streamer_if #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_idx;

    modport master (output out_valid, output out_data, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/index_unpacked_regfile.sv
// rtl/index_unpacked_regfile.sv - flop array with range-checked write port and read mux
// Ports: clk, rst (async active-high), wr_en/wr_idx/wr_data write port,
//        wr_err (one-cycle pulse on out-of-range write), rd_idx -> rd_data (combinational).
module index_unpacked_regfile
    import index_unpacked_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_err,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_in_range;
    logic             rd_in_range;

    // Extra top bit so DEPTH itself is representable in the compare.
    assign wr_in_range = ({1'b0, wr_idx} < (IDX_W+1)'(DEPTH));
    assign rd_in_range = ({1'b0, rd_idx} < (IDX_W+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WIDTH'(reset_byte(i));
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_in_range;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_in_range && (wr_idx == IDX_W'(i))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Reads see flop contents, so a same-edge write and load returns the old value.
    assign rd_data = rd_in_range ? mem[rd_idx] : '0;

endmodule

// File: rtl/index_unpacked_streamer.sv
// rtl/index_unpacked_streamer.sv - streams an unpacked register array as indexed beats
// Ports: clk, rst (async active-high), wr_en/wr_idx/wr_data element write, start,
//        busy, done (one-cycle pulse), wr_err, stream (master: out_valid/out_data/out_idx/out_ready).
// Optional macro INDEX_UNPACKED_STREAMER_CSUM_EN appends an XOR checksum beat.
module index_unpacked_streamer
    import index_unpacked_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             wr_err,
    index_unpacked_streamer_if.master stream
);

    state_t           state;
    state_t           state_nxt;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             accept;
    logic             last_beat;
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
    logic [WIDTH-1:0] csum_q;
`endif

    index_unpacked_regfile #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign accept    = valid_q & stream.out_ready;
    assign last_beat = (idx_q == IDX_W'(DEPTH-1));
    // Address of the beat that the next load would take.
    assign rd_idx    = (state == IDLE) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
            STREAM:  if (accept && last_beat) state_nxt = CSUM;
            CSUM:    if (accept) state_nxt = DONE;
`else
            STREAM:  if (accept && last_beat) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Output register: a beat is captured from the array at load time and held
    // until accepted, so later writes to its index cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        data_q  <= rd_data;
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                STREAM: begin
                    if (accept) begin
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
                        csum_q <= csum_q ^ data_q;
`endif
                        if (!last_beat) begin
                            idx_q  <= idx_q + 1'b1;
                            data_q <= rd_data;
                        end else begin
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
                            // Checksum beat reuses the last index; valid stays high.
                            data_q <= csum_q ^ data_q;
`else
                            valid_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
                CSUM: begin
                    if (accept) valid_q <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign stream.out_valid = valid_q;
    assign stream.out_data  = data_q;
    assign stream.out_idx   = idx_q;

endmodule

// File: tb/tb_index_unpacked_streamer.sv
// tb/tb_index_unpacked_streamer.sv - scoreboard bench for index_unpacked_streamer
module tb_index_unpacked_streamer;
    import index_unpacked_pkg::*;

    localparam int DEPTH = 3;
    localparam int WIDTH = 8;
    localparam int IDX_W = 2;
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
    localparam int NBEATS = 4;
`else
    localparam int NBEATS = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             busy;
    logic             done;
    logic             wr_err;

    index_unpacked_streamer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) stream_if ();

    index_unpacked_streamer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .wr_err  (wr_err),
        .stream  (stream_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t  sb[$];
    entry_t model [DEPTH];
    int     checks_total = 0;
    int     checks_passed = 0;
    int     cyc = 0;
    int     nbeats = 0;
    int     first_cyc = 0;
    int     last_cyc = 0;
    int     done_cyc = 0;
    int     done_count = 0;
    int     start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (stream_if.out_valid && stream_if.out_ready && !rst) begin
            beat_t exp_b;
            if (nbeats == 0) first_cyc = cyc;
            last_cyc = cyc;
            nbeats++;
            check("beat_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_b = sb.pop_front();
                check("beat_idx", stream_if.out_idx, exp_b.idx);
                check("beat_data", stream_if.out_data, exp_b.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model[0] = 8'hAA;
        model[1] = 8'hBB;
        model[2] = 8'hCC;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_stream(input entry_t b0, input entry_t b1, input entry_t b2);
        sb.push_back({2'd0, b0});
        sb.push_back({2'd1, b1});
        sb.push_back({2'd2, b2});
`ifdef INDEX_UNPACKED_STREAMER_CSUM_EN
        sb.push_back({2'd2, b0 ^ b1 ^ b2});
`endif
        nbeats = 0;
    endtask

    task automatic write_elem(input logic [IDX_W-1:0] idx, input entry_t data);
        wr_en = 1'b1;
        wr_idx = idx;
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (idx < DEPTH) model[idx] = data;
    endtask

    task automatic start_stream();
        start_cyc = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_idx = '0;
        wr_data = '0;
        start = 1'b0;
        stream_if.out_ready = 1'b1;
        model_reset();
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(stream_if.out_valid), 32'd0);
        check("rst_out_data", stream_if.out_data, 32'd0);
        check("rst_out_idx", stream_if.out_idx, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_err", 32'(wr_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset-value stream at full throughput.
        push_stream(model[0], model[1], model[2]);
        start_stream();
        wait_done("t1");
        check("t1_nbeats", nbeats, NBEATS);
        check("t1_first_latency", first_cyc - start_cyc, 32'd1);
        check("t1_back_to_back", last_cyc - first_cyc, NBEATS - 1);
        check("t1_done_after_last", done_cyc - last_cyc, 32'd1);

        // Write before stream.
        write_elem(2'd0, 8'hDD);
        push_stream(model[0], model[1], model[2]);
        start_stream();
        wait_done("t2");

        // Same-edge write and load of index 1 returns the old value.
        push_stream(model[0], model[1], model[2]);
        start_stream();
        wr_en = 1'b1;
        wr_idx = 2'd1;
        wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        model[1] = 8'h77;
        wait_done("t3");
        push_stream(model[0], model[1], model[2]);
        start_stream();
        wait_done("t3b");

        // Held beat stable under backpressure; later index picks up new write.
        do_reset();
        stream_if.out_ready = 1'b0;
        push_stream(8'hAA, 8'hBB, 8'h22);
        start_stream();
        wr_en = 1'b1;
        wr_idx = 2'd0;
        wr_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(stream_if.out_valid), 32'd1);
            check("t4_hold_data", stream_if.out_data, 32'hAA);
            check("t4_hold_idx", stream_if.out_idx, 32'd0);
            tick();
            wr_en = 1'b0;
            start = (i == 0);
        end
        start = 1'b0;
        write_elem(2'd2, 8'h22);
        model[0] = 8'h11;
        stream_if.out_ready = 1'b1;
        wait_done("t4");

        // Out-of-range write.
        do_reset();
        write_elem(2'd3, 8'hEE);
        @(negedge clk);
        check("t5_wr_err_pulse", 32'(wr_err), 32'd1);
        @(negedge clk);
        check("t5_wr_err_clear", 32'(wr_err), 32'd0);
        tick();
        push_stream(8'hAA, 8'hBB, 8'hCC);
        start_stream();
        wait_done("t5");

        // Reset during beat 1.
        push_stream(8'hAA, 8'hBB, 8'hCC);
        start_stream();
        tick();
        check("t6_in_beat1_idx", stream_if.out_idx, 32'd1);
        dc = done_count;
        rst = 1'b1;
        sb.delete();
        model_reset();
        #1;
        check("t6_rst_valid", 32'(stream_if.out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_done", done_count, dc);
        tick();
        push_stream(8'hAA, 8'hBB, 8'hCC);
        start_stream();
        wait_done("t6");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/index_unpacked_streamer.md
INDEX_UNPACKED_STREAMER -- requirements
Module: index_unpacked_streamer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3, giving the number of entries in the unpacked byte array.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the bits per array entry.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write strobe for one array element.
REQ-006 The block SHALL have port wr_idx, input, $clog2(DEPTH) bits: index of the element to write.
REQ-007 The block SHALL have port wr_data, input, WIDTH bits: the new element value.
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle request to stream the whole array.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the current beat.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data and out_idx hold a valid beat.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the streamed element value.
REQ-012 The block SHALL have port out_idx, output, $clog2(DEPTH) bits: the index of the streamed element.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final beat is accepted.
REQ-015 The block SHALL have port wr_err, output, 1 bit: one-cycle pulse flagging an out-of-range write.

Function
REQ-016 The array SHALL be an unpacked array of DEPTH entries of WIDTH bits, held in flops.
REQ-017 A write with wr_en=1 and wr_idx<DEPTH SHALL update exactly entry wr_idx on the next edge, in any FSM state.
REQ-018 A write with wr_en=1 and wr_idx>=DEPTH SHALL leave the array unchanged and pulse wr_err on the next cycle.
REQ-019 FSM states SHALL be IDLE, STREAM and DONE.
REQ-020 IDLE + start: SHALL enter STREAM, load beat index 0 into the output register, and raise out_valid on the next cycle.
REQ-021 In STREAM, out_data/out_idx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 In STREAM, on out_valid&out_ready with idx<DEPTH-1: SHALL load entry idx+1 next cycle, giving zero bubbles and one beat per cycle.
REQ-023 In STREAM, on acceptance of the last beat: SHALL go to DONE with out_valid=0.
REQ-024 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-025 The output register SHALL sample array contents at load time; a write to an already-loaded beat's index SHALL NOT alter the held beat.
REQ-026 A write to a not-yet-loaded index SHALL be reflected when that index is loaded; a same-cycle write and load of one index SHALL load the old value.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 The index counter SHALL NOT wrap; DEPTH=1 SHALL produce a single beat and then DONE.

Reset
REQ-029 On rst, array entries SHALL initialise to {8'hAA, 8'hBB, 8'hCC} for DEPTH=3 and WIDTH=8; for other DEPTH values the entry at index i SHALL initialise to 8'hAA+i*8'h11, truncated/zero-extended to WIDTH.
REQ-030 On rst, the FSM SHALL enter IDLE, and out_valid, out_data, out_idx, busy, done and wr_err SHALL all be 0.
REQ-031 Reset mid-stream SHALL abort immediately with no done pulse and return to the reset array contents.

Configuration
REQ-032 With INDEX_UNPACKED_STREAMER_CSUM_EN defined, the block SHALL add state CSUM after the last element beat.
REQ-033 In CSUM, the block SHALL emit one extra beat with out_data equal to the XOR of all DEPTH beats actually sent and out_idx = DEPTH-1, under the same handshake, before going to DONE.
REQ-034 Without INDEX_UNPACKED_STREAMER_CSUM_EN, the block SHALL have no CSUM state and no checksum logic.

Structure
REQ-035 A shared package index_unpacked_pkg SHALL hold the entry typedef, the unpacked-array typedef, the FSM state enum and the reset-value function.
REQ-036 One sub-module, index_unpacked_regfile, SHALL hold the array flops, the write-port range check and the combinational read mux; the FSM and output register SHALL stay in the top.

Verification
REQ-037 Reset, start, out_ready=1 throughout SHALL give beats (0,AA), (1,BB), (2,CC) on consecutive cycles, then a done pulse.
REQ-038 wr_en, idx=0, data=DD, then stream SHALL give beats DD, BB, CC.
REQ-039 During a stream, beat 0 held with out_ready=0 for 3 cycles while idx=0 is written with 11 SHALL keep out_data=AA stable; a write of 22 to idx=2 before beat 2 loads SHALL give beat 2 = 22.
REQ-040 wr_idx=3 with data=EE SHALL pulse wr_err once and leave a subsequent stream as AA, BB, CC.
REQ-041 rst asserted during beat 1 SHALL clear out_valid and busy immediately with no done pulse; the next stream SHALL give AA, BB, CC.
REQ-042 With CSUM_EN defined, the reset-value stream SHALL end with a fourth beat of data 0xDD (AA^BB^CC) before done.
